serial_subtractor: RTL

//   Bit-serial two's-complement subtractor: computes diff = a - b, one bit per clock, LSB first.
//   It is the inverse-direction companion to the parallel ripple adder.

---
 rtl/arith_pkg.sv | 16 +
 rtl/serial_subtractor_if.sv | 18 +
 rtl/sub_bit_cell.sv | 11 +
 rtl/serial_subtractor.sv | 104 ++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: FSM state encoding and counter-width helper
// for the bit-serial subtractor.
package arith_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  // Bit counter only has to reach WIDTH-1; keep at least one bit.
  function automatic int cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the bit-serial subtractor; master = requester,
// slave = the subtractor itself.
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;

  modport master (output start, a, b,
                  input  ready, busy, done, diff, borrow, ovf);
  modport slave  (input  start, a, b,
                  output ready, busy, done, diff, borrow, ovf);
endinterface

// File: rtl/sub_bit_cell.sv
// One-bit full-adder cell; the caller feeds the already-inverted subtrahend bit.
module sub_bit_cell (
  input  logic a_i,
  input  logic b_n_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);
  assign s_o    = a_i ^ b_n_i ^ cin_i;
  assign cout_o = (a_i & b_n_i) | (a_i & cin_i) | (b_n_i & cin_i);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = a - b, LSB first, a + ~b + 1).
// Define SERIAL_SUB_OVF_EN to build the signed-overflow flag; otherwise ovf is tied to 0.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, acc_q, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q, borrow_q;
  logic             s, cout, accept, last;

  assign accept = (state_q == ST_IDLE) && bus.start;
  assign last   = (state_q == ST_SHIFT) && (cnt_q == CW'(WIDTH - 1));

  sub_bit_cell u_cell (
    .a_i   (a_q[0]),
    .b_n_i (~b_q[0]),
    .cin_i (c_q),
    .s_o   (s),
    .cout_o(cout)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_SHIFT;
      ST_SHIFT: if (last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // acc_q collects sum bits; diff_q only updates on DONE entry so the visible
  // result stays stable while the next operation is shifting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q   <= bus.a;
        b_q   <= bus.b;
        acc_q <= '0;
        c_q   <= 1'b1;
        cnt_q <= '0;
      end else if (state_q == ST_SHIFT) begin
        a_q   <= a_q >> 1;
        b_q   <= b_q >> 1;
        acc_q <= {s, acc_q[WIDTH-1:1]};
        c_q   <= cout;
        cnt_q <= cnt_q + 1'b1;
        if (last) begin
          diff_q   <= {s, acc_q[WIDTH-1:1]};
          borrow_q <= ~cout;
        end
      end
    end
  end

  assign bus.ready  = (state_q == ST_IDLE);
  assign bus.busy   = (state_q == ST_SHIFT);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q, b_msb_q, ovf_q;

  // On the last shift edge s is the result MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept) begin
        a_msb_q <= bus.a[WIDTH-1];
        b_msb_q <= bus.b[WIDTH-1];
      end
      if (last) ovf_q <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ s);
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

endmodule
